// File: rtl/nand_flash_responder.sv
// Target-side model of an 8-bit small-page NAND flash (256 KiB array).
// Decodes command/address/data cycles from oversampled strobes, drives ready/busy and read data.
module nand_flash_responder #(
  parameter int unsigned T_READ        = 8,
  parameter int unsigned T_PROG        = 32,
  parameter int unsigned T_RST         = 4,
  parameter int unsigned PAGES_PER_BLK = 32
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] F_IO,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_WEN,
  input  logic       F_REN,
  output logic       F_RB
);

  localparam int unsigned AW        = 18;
  localparam int unsigned MEM_BYTES = 1 << AW;
  localparam int unsigned ERASE_LEN = PAGES_PER_BLK * 512;
  localparam int unsigned EW        = $clog2(ERASE_LEN);
  localparam int unsigned BCW       = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RADDR,
    ST_PADDR,
    ST_PDATA,
    ST_EADDR,
    ST_ERASE,
    ST_BUSY,
    ST_RDATA,
    ST_STATUS
  } state_t;

  // Contents are stored inverted so the all-zero power-up image reads back as erased 0xFF.
  logic [7:0] mem_n [MEM_BYTES];

  logic           we_s1, we_s2, we_s3;
  logic           re_s1, re_s2, re_s3;
  logic           cle_s1, cle_s2, ale_s1, ale_s2;
  logic [7:0]     io_s1, io_s2;

  state_t         state, bnext;
  logic [AW-1:0]  addr;
  logic [1:0]     acnt;
  logic [BCW-1:0] bcnt;
  logic [EW-1:0]  ecnt;
  logic [7:0]     dout;
  logic           oe, rd_data, stat;

  logic we_ev_c, re_ev_c, re_rise_c, cmd_c, adr_c, dat_c, busy_c;
  logic prog_we_c, erase_we_c;

  // Double-register every bus input; a third WEN/REN stage gives edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_s1  <= 1'b1;
      we_s2  <= 1'b1;
      we_s3  <= 1'b1;
      re_s1  <= 1'b1;
      re_s2  <= 1'b1;
      re_s3  <= 1'b1;
      cle_s1 <= 1'b0;
      cle_s2 <= 1'b0;
      ale_s1 <= 1'b0;
      ale_s2 <= 1'b0;
      io_s1  <= 8'h00;
      io_s2  <= 8'h00;
    end else begin
      we_s1  <= F_WEN;
      we_s2  <= we_s1;
      we_s3  <= we_s2;
      re_s1  <= F_REN;
      re_s2  <= re_s1;
      re_s3  <= re_s2;
      cle_s1 <= F_CLE;
      cle_s2 <= cle_s1;
      ale_s1 <= F_ALE;
      ale_s2 <= ale_s1;
      io_s1  <= F_IO;
      io_s2  <= io_s1;
    end
  end

  assign we_ev_c    = we_s2 & ~we_s3;
  assign re_ev_c    = ~re_s2 & re_s3;
  assign re_rise_c  = re_s2 & ~re_s3;
  assign cmd_c      = we_ev_c & cle_s2 & ~ale_s2;
  assign adr_c      = we_ev_c & ~cle_s2 & ale_s2;
  assign dat_c      = we_ev_c & ~cle_s2 & ~ale_s2;
  assign busy_c     = (state == ST_BUSY) || (state == ST_ERASE);
  assign prog_we_c  = dat_c && (state == ST_PDATA);
  assign erase_we_c = (state == ST_ERASE);

  // Array writes: programming can only clear bits (set bits in the inverted store).
  always_ff @(posedge clk) begin
    if (rst) begin
      if (erase_we_c)
        mem_n[{addr[AW-1:EW], ecnt}] <= 8'h00;
      else if (prog_we_c)
        mem_n[addr] <= mem_n[addr] | ~io_s2;
    end
  end

  // Bus is released whenever a write strobe is low or CLE/ALE is seen.
  assign F_IO = (oe && we_s2 && !cle_s2 && !ale_s2) ? dout : 8'bz;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bnext   <= ST_IDLE;
      F_RB    <= 1'b1;
      oe      <= 1'b0;
      rd_data <= 1'b0;
      stat    <= 1'b0;
      addr    <= '0;
      acnt    <= 2'd0;
      bcnt    <= '0;
      ecnt    <= '0;
      dout    <= 8'h00;
    end else begin
      if (re_rise_c && oe) begin
        oe <= 1'b0;
        if (rd_data)
          addr[8:0] <= addr[8:0] + 9'd1;
      end
      if (re_ev_c && !we_ev_c && (stat || state == ST_RDATA)) begin
        oe      <= 1'b1;
        rd_data <= !stat;
        dout    <= stat ? (busy_c ? 8'h80 : 8'hC0) : ~mem_n[addr];
      end
      if (we_ev_c)
        oe <= 1'b0;

      case (state)
        ST_BUSY: begin
          if (bcnt == '0) begin
            F_RB  <= 1'b1;
            state <= bnext;
          end else begin
            bcnt <= bcnt - BCW'(1);
          end
        end
        ST_ERASE: begin
          if (ecnt == EW'(ERASE_LEN - 1)) begin
            F_RB  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            ecnt <= ecnt + EW'(1);
          end
        end
        ST_RADDR, ST_PADDR: begin
          if (adr_c) begin
            case (acnt)
              2'd0:    addr[7:0]  <= io_s2;
              2'd1:    addr[16:9] <= io_s2;
              default: addr[17]   <= io_s2[0];
            endcase
            acnt <= acnt + 2'd1;
            if (acnt == 2'd2) begin
              if (state == ST_RADDR) begin
                state <= ST_BUSY;
                bnext <= ST_RDATA;
                bcnt  <= BCW'(T_READ - 1);
                F_RB  <= 1'b0;
              end else begin
                state <= ST_PDATA;
              end
            end
          end
        end
        ST_PDATA: begin
          if (dat_c)
            addr[8:0] <= addr[8:0] + 9'd1;
        end
        ST_EADDR: begin
          if (adr_c && acnt < 2'd2) begin
            if (acnt == 2'd0)
              addr[16:9] <= io_s2;
            else
              addr[17] <= io_s2[0];
            acnt <= acnt + 2'd1;
          end
        end
        default: ;
      endcase

      // Command decode; reset and status are the only commands honoured while busy.
      if (cmd_c) begin
        if (io_s2 == 8'hFF) begin
          state   <= ST_BUSY;
          bnext   <= ST_IDLE;
          bcnt    <= BCW'(T_RST - 1);
          F_RB    <= 1'b0;
          addr[8] <= 1'b0;
          stat    <= 1'b0;
          acnt    <= 2'd0;
        end else if (io_s2 == 8'h70) begin
          stat <= 1'b1;
          if (!busy_c)
            state <= ST_STATUS;
        end else if (!busy_c) begin
          stat <= 1'b0;
          if (state == ST_RDATA || state == ST_STATUS)
            state <= ST_IDLE;
          case (io_s2)
            8'h00, 8'h01: begin
              addr[8] <= io_s2[0];
              acnt    <= 2'd0;
              state   <= ST_RADDR;
            end
            8'h80: begin
              acnt  <= 2'd0;
              state <= ST_PADDR;
            end
            8'h60: begin
              acnt  <= 2'd0;
              state <= ST_EADDR;
            end
            8'h10: begin
              if (state == ST_PDATA) begin
                state <= ST_BUSY;
                bnext <= ST_IDLE;
                bcnt  <= BCW'(T_PROG - 1);
                F_RB  <= 1'b0;
              end
            end
            8'hD0: begin
              if (state == ST_EADDR && acnt == 2'd2) begin
                state <= ST_ERASE;
                ecnt  <= '0;
                F_RB  <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nand_flash_responder.sv
// Scoreboard bench for nand_flash_responder: expected read bytes and busy lengths are queued
// by the stimulus thread and checked by monitors on F_REN rising and F_RB low periods.
module tb_nand_flash_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       F_CLE, F_ALE, F_WEN, F_REN;
  logic [7:0] drv;
  logic       drv_en;
  logic       rst_done;
  wire  [7:0] F_IO;
  wire        F_RB;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_data [$];
  int         exp_busy [$];

  assign F_IO = drv_en ? drv : 8'bz;

  always #5 clk = ~clk;

  nand_flash_responder dut (
    .clk   (clk),
    .rst   (rst),
    .F_IO  (F_IO),
    .F_CLE (F_CLE),
    .F_ALE (F_ALE),
    .F_WEN (F_WEN),
    .F_REN (F_REN),
    .F_RB  (F_RB)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wcyc(input logic cle, input logic ale, input logic [7:0] v);
    @(negedge clk);
    F_CLE = cle; F_ALE = ale; drv = v; drv_en = 1'b1; F_WEN = 1'b0;
    repeat (3) @(negedge clk);
    F_WEN = 1'b1;
    repeat (2) @(negedge clk);
    drv_en = 1'b0; F_CLE = 1'b0; F_ALE = 1'b0;
    @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] v); wcyc(1'b1, 1'b0, v); endtask
  task automatic adr(input logic [7:0] v); wcyc(1'b0, 1'b1, v); endtask
  task automatic dat(input logic [7:0] v); wcyc(1'b0, 1'b0, v); endtask

  task automatic rd_pulse();
    @(negedge clk);
    F_REN = 1'b0;
    repeat (4) @(negedge clk);
    F_REN = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (F_RB !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", int'(n < 30000), 1);
  endtask

  task automatic read_at(input logic [7:0] c, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2);
    cmd(c);
    adr(a0);
    adr(a1);
    exp_busy.push_back(8);
    adr(a2);
    wait_ready();
  endtask

  task automatic prog(input logic [7:0] c, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] a2, input int n, input logic [7:0] d0,
                      input logic [7:0] d1);
    cmd(c);
    cmd(8'h80);
    adr(a0);
    adr(a1);
    adr(a2);
    dat(d0);
    if (n > 1) dat(d1);
    exp_busy.push_back(32);
    cmd(8'h10);
    wait_ready();
  endtask

  // Read-data monitor: the byte on F_IO just before the read strobe rises.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge F_REN);
      if (exp_data.size() > 0) begin
        e = exp_data.pop_front();
        check("read_byte", int'(F_IO), int'(e));
      end
    end
  end

  // Busy monitor: length of every F_RB low period in clk cycles.
  initial begin
    int n;
    forever begin
      @(negedge F_RB);
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (F_RB == 1'b0 && n < 20000);
      if (exp_busy.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL busy_unexpected: got low for %0d cycles, expected none", n);
      end else begin
        check("busy_len", n, exp_busy.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; F_CLE = 1'b0; F_ALE = 1'b0; F_WEN = 1'b1; F_REN = 1'b1;
    drv = 8'h00; drv_en = 1'b0; rst_done = 1'b0;
    repeat (4) @(negedge clk);
    check("rb_in_reset", int'(F_RB), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    exp_busy.push_back(4);
    cmd(8'hFF);
    wait_ready();
    check("rb_after_reset_cmd", int'(F_RB), 1);

    // Program two bytes at 0x00605 and read them back.
    prog(8'h00, 8'h05, 8'h03, 8'h00, 2, 8'hA5, 8'h3C);
    read_at(8'h00, 8'h05, 8'h03, 8'h00);
    exp_data.push_back(8'hA5); exp_data.push_back(8'h3C);
    rd_pulse(); rd_pulse();

    // Second half-page pointer: 0x1FF then column wraps to 0x000 on page 0.
    prog(8'h01, 8'hFF, 8'h00, 8'h00, 2, 8'h11, 8'h22);
    read_at(8'h01, 8'hFF, 8'h00, 8'h00);
    exp_data.push_back(8'h11); exp_data.push_back(8'h22);
    rd_pulse(); rd_pulse();
    read_at(8'h00, 8'h00, 8'h01, 8'h00);
    exp_data.push_back(8'hFF);
    rd_pulse();

    // Overwrite without erase: 0xA5 & 0x5A.
    prog(8'h00, 8'h05, 8'h03, 8'h00, 1, 8'h5A, 8'h00);
    read_at(8'h00, 8'h05, 8'h03, 8'h00);
    exp_data.push_back(8'h00); exp_data.push_back(8'h3C);
    rd_pulse(); rd_pulse();

    // Block 0 erase; 0x04000 lives in block 1 and must survive.
    prog(8'h00, 8'h00, 8'h20, 8'h00, 1, 8'h77, 8'h00);
    cmd(8'h60);
    adr(8'h00);
    adr(8'h00);
    exp_busy.push_back(16384);
    cmd(8'hD0);
    wait_ready();
    read_at(8'h00, 8'h05, 8'h03, 8'h00);
    exp_data.push_back(8'hFF);
    rd_pulse();
    read_at(8'h00, 8'h00, 8'h20, 8'h00);
    exp_data.push_back(8'h77);
    rd_pulse();

    // Status during programme busy; a read command while busy is dropped.
    cmd(8'h00);
    cmd(8'h80);
    adr(8'h10); adr(8'h00); adr(8'h00);
    dat(8'h99);
    exp_busy.push_back(32);
    cmd(8'h10);
    cmd(8'h70);
    exp_data.push_back(8'h80);
    rd_pulse();
    cmd(8'h00);
    exp_data.push_back(8'h80);
    rd_pulse();
    wait_ready();
    exp_data.push_back(8'hC0);
    rd_pulse();
    read_at(8'h00, 8'h10, 8'h00, 8'h00);
    exp_data.push_back(8'h99);
    rd_pulse();

    // Reset 100 cycles into a block erase at 0x08000.
    prog(8'h00, 8'h5A, 8'h40, 8'h00, 1, 8'h12, 8'h00);
    prog(8'h00, 8'h6E, 8'h40, 8'h00, 1, 8'h34, 8'h00);
    cmd(8'h60);
    adr(8'h40);
    adr(8'h00);
    exp_busy.push_back(100);
    fork
      begin
        @(negedge F_RB);
        repeat (100) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rb_after_rst_pin", int'(F_RB), 1);
        rst = 1'b1;
        rst_done = 1'b1;
      end
    join_none
    cmd(8'hD0);
    begin
      int n;
      n = 0;
      while (!rst_done && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("rst_mid_erase_wait", int'(rst_done), 1);
    end
    repeat (2) @(negedge clk);
    read_at(8'h00, 8'h5A, 8'h40, 8'h00);
    exp_data.push_back(8'hFF);
    rd_pulse();
    read_at(8'h00, 8'h6E, 8'h40, 8'h00);
    exp_data.push_back(8'h34);
    rd_pulse();

    repeat (20) @(negedge clk);
    check("data_queue_drained", exp_data.size(), 0);
    check("busy_queue_drained", exp_busy.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nand_flash_responder.md
Name: nand_flash_responder

Overview:
- Synthesizable target-side model of the 8-bit small-page NAND flash driven by the flash controller.
- Decodes command, address and data cycles on F_IO/F_CLE/F_ALE/F_WEN/F_REN.
- Holds a 256 KiB byte array, drives F_RB busy periods and returns read data on F_IO.
- Used as the bench flash and the FPGA loop-back target.

Parameters:
- T_READ, 8, F_RB low cycles after the third read address byte.
- T_PROG, 32, F_RB low cycles after the 0x10 confirm.
- T_RST, 4, F_RB low cycles after the 0xFF reset command.
- PAGES_PER_BLK, 32, pages erased per 0x60/0xD0 sequence (page = 512 B).

Ports:
- clk  in  1  system clock; oversamples the strobes, at least 4x the strobe rate.
- rst  in  1  synchronous, active-low reset.
- F_IO  inout  8  flash bus; driven only while returning read or status data.
- F_CLE  in  1  command latch enable.
- F_ALE  in  1  address latch enable.
- F_WEN  in  1  write strobe; F_IO is latched on its rising edge.
- F_REN  in  1  read strobe; data is presented after its falling edge.
- F_RB  out  1  ready/busy; 0 = busy.

Behaviour:
- Strobe sampling:
  - F_WEN, F_REN, F_CLE, F_ALE and F_IO are registered twice before use.
  - A WE event is a registered 0->1 transition of F_WEN; CLE/ALE/IO are taken from the same sample.
  - An RE event is a registered 1->0 transition of F_REN.
- Reset (rst=0 at posedge clk):
  - state=IDLE, F_RB=1, F_IO hi-Z.
  - half=0, addr=0, busy counter=0, address-cycle count=0.
  - The array is not touched by reset; it is initialised to 0xFF at time zero.
- Address: addr[17:0] = {A17, A16..A9, half, A7..A0}.
  - Byte0 gives A7:0, byte1 gives A16:9, byte2 bit0 gives A17.
  - Byte2 bits 7:1 are ignored.
- Command decode (WE event with CLE=1, ALE=0):
  - 0x00/0x01: half=0/1; state=RADDR; address-cycle count=0.
  - 0x80: state=PADDR.
  - 0x10: valid only in PDATA; start programme busy (T_PROG).
  - 0x60: state=EADDR.
  - 0xD0: valid only in EADDR after 2 address bytes.
  - 0x70: state=STATUS.
  - 0xFF: accepted in any state, including busy. Aborts the current operation; half=0; busy T_RST; then IDLE.
  - Any other command, or a command received while busy (except 0xFF and 0x70): ignored; state unchanged.
- States:
  - IDLE.
  - RADDR: 3 address bytes, then BUSY(T_READ), then RDATA.
  - PADDR: 3 address bytes, then PDATA.
  - PDATA: each WE event with CLE=0 and ALE=0 programs the byte as mem[addr] <= mem[addr] & F_IO (bits only clear), then increments the column.
  - EADDR: 2 address bytes giving A16:9 and A17; then 0xD0 enters ERASE.
  - ERASE: F_RB=0; clears one byte to 0xFF per clk from block base {A17, A16:14, 14'b0}; length PAGES_PER_BLK*512 bytes; then IDLE.
  - BUSY: F_RB=0 for exactly the parameter count of clk cycles, then F_RB=1 and the next state.
  - RDATA: on each RE event, F_IO is driven with mem[addr] from the next clk until the registered rising edge of F_REN, then the column increments.
  - STATUS: on an RE event, drives 0xC0 when ready, or 0x80 while busy; 0x70 is accepted during busy.
  - Any WE event with CLE=1 leaves RDATA or STATUS.
- Column increment: the 9-bit column {half, A7:0} increments within the page and wraps 511 -> 0; page bits never change.
- ALE bytes outside an address state are ignored. More than the expected number of address bytes: extra bytes are ignored.
- Bus rules:
  - F_IO is never driven while F_WEN is low or while CLE=1 or ALE=1 is sampled.
  - Simultaneous WE and RE events: the WE event wins; RE is ignored.
- Reset during busy or erase: the operation stops immediately and F_RB=1 on the next cycle. A partially erased block keeps already-cleared bytes.

Test Plan:
- Reset, then CLE 0xFF -> F_RB low exactly 4 clk, high afterwards; F_IO hi-Z throughout.
- Program: 0x80, addr bytes 0x05,0x03,0x00, data 0xA5,0x3C, 0x10 -> F_RB low 32 clk. Then 0x00 with the same address and two RE pulses -> F_IO 0xA5, 0x3C.
- Half select: 0x01 with addr bytes 0xFF,0x00,0x00 programmed with 0x11,0x22 -> bytes land at 0x1FF and 0x000. Column wrap stays on page 0.
- Overwrite 0xA5 with 0x5A at the same address, no erase -> readback 0x00 (AND semantics).
- Erase: 0x60, 0x00, 0x00, 0xD0 -> F_RB low 16384 clk; readback of 0x00005 = 0xFF. A byte at 0x04000 is unchanged.
- 0x70 during T_PROG busy -> RE returns 0x80; after ready returns 0xC0. A 0x00 command during busy is ignored.
- rst=0 mid-erase -> F_RB=1 next cycle; a following read returns a mix of 0xFF and old data at the boundary.
